brick_lightning_anim_ctrl: RTL and testbench
============================================

Name: brick_lightning_anim_ctrl

Overview:
Animation sequencer for the lightning-brick sprite. It selects which sprite frame (ROM/palette set) the pixel pipeline draws for a brick: frame 0 is the idle brick, frames 1..NUM_FRAMES are the lightning frames. It sits beside the brick's sprite ROM and palette in the draw path. A one-cycle hit trigger starts the strike; the per-VGA-frame tick paces the sequence.

Parameters:
NUM_FRAMES, 4, number of lightning frames (frame_sel range 1..NUM_FRAMES); must be >= 2
TICKS_PER_FRAME, 3, frame_tick pulses each animation frame is displayed
HOLD_REPEATS, 2, number of (NUM_FRAMES-1, NUM_FRAMES) pairs shown in HOLD
FRAME_W, 3, width of frame_sel; must hold NUM_FRAMES

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
enable  input  1  animation enable; low forces IDLE
frame_tick  input  1  one-cycle pulse per VGA frame (vsync)
trigger  input  1  one-cycle hit pulse, starts or retriggers the strike
frame_sel  output  FRAME_W  sprite frame to draw; 0 = idle brick
active  output  1  high while the state is not IDLE
done  output  1  one-cycle pulse when DECAY completes normally
state_o  output  2  debug state code: IDLE=0, STRIKE=1, HOLD=2, DECAY=3

Behaviour:
- All outputs are registered. Outputs update the cycle after the causing input.
- Reset (synchronous, Clk edge with Reset=1): state IDLE, frame_sel=0, active=0, done=0, state_o=0, tick_cnt=0, per_cnt=0. Reset has priority over every other input, including mid-sequence.
- tick_cnt counts frame_tick pulses within a period, from 0 to TICKS_PER_FRAME-1. A period ends on the frame_tick where tick_cnt==TICKS_PER_FRAME-1; tick_cnt then returns to 0. Cycles without frame_tick do not change the counters.
- IDLE: frame_sel=0. trigger&enable -> STRIKE, frame_sel=1, tick_cnt=0. If trigger and frame_tick arrive together, trigger wins and the tick is not counted.
- STRIKE: at each period end, if frame_sel<NUM_FRAMES then frame_sel+1. If frame_sel==NUM_FRAMES then -> HOLD, frame_sel=NUM_FRAMES-1, per_cnt=0. trigger is ignored.
- HOLD: at each period end, frame_sel toggles between NUM_FRAMES-1 and NUM_FRAMES and per_cnt+1. After 2*HOLD_REPEATS periods -> DECAY, frame_sel=NUM_FRAMES-1. A trigger sets per_cnt=0 and tick_cnt=0 and leaves frame_sel unchanged.
- DECAY: at each period end, frame_sel-1 while frame_sel>1. When the frame_sel==1 period ends: -> IDLE, frame_sel=0, done=1 for exactly one cycle. A trigger -> STRIKE, keeps the current frame_sel, tick_cnt=0.
- With default parameters, the frame_sel sequence per period is 1,2,3,4,3,4,3,4,3,2,1, then 0. That is 33 ticks total.
- enable=0 in any state: next cycle IDLE, frame_sel=0, counters 0, no done pulse. Higher priority than trigger and frame_tick.
- active=(state!=IDLE); active and done are never both 1 in the same cycle.
- Counter widths are sized with $clog2 of their maxima; no wrap occurs within the legal ranges.

Optional Feature:
Macro BRICK_LIGHTNING_FLICKER_EN.
- Defined: a 4-bit LFSR (x^4+x^3+1) is added, seeded to 4'b1001 on Reset and advanced on every frame_tick while in HOLD.
  - While in HOLD and the LFSR's bit0==1, frame_sel outputs 0 (brick blanks).
  - The internal alternation and per_cnt timing are unchanged.
- Not defined: no LFSR is built and HOLD shows the deterministic alternation only.

Test Plan:
1. Reset, enable=1, one trigger, then 40 frame_ticks spaced 5 cycles apart (defaults) -> frame_sel follows 1,2,3,4,3,4,3,4,3,2,1, three ticks each. After the 33rd tick frame_sel=0, active=0, done=1 for exactly one cycle.
2. trigger and frame_tick in the same cycle while IDLE -> STRIKE with frame_sel=1; frame 1 still lasts a full 3 subsequent ticks.
3. trigger after 2 of the 3 ticks of DECAY frame 2 -> STRIKE, frame_sel=2 held for 3 ticks, then 3, 4, then HOLD restarts. No done pulse.
4. trigger during HOLD after 3 periods -> HOLD lasts 4 more full periods before DECAY.
5. enable dropped mid-STRIKE at frame_sel=3 -> next cycle frame_sel=0, active=0, state_o=0, done stays 0. Reset asserted mid-HOLD -> same values.
6. With BRICK_LIGHTNING_FLICKER_EN defined, run scenario 1 -> HOLD ticks show frame_sel=0 exactly where the LFSR bit0=1, sequence checked against a reference LFSR from seed 4'b1001. Total length is still 33 ticks.

Source files
------------

// File: rtl/brick_lightning_anim_ctrl.sv
// brick_lightning_anim_ctrl: lightning-brick sprite frame sequencer (optional HOLD flicker via BRICK_LIGHTNING_FLICKER_EN)
module brick_lightning_anim_ctrl #(
  parameter int NUM_FRAMES      = 4,
  parameter int TICKS_PER_FRAME = 3,
  parameter int HOLD_REPEATS    = 2,
  parameter int FRAME_W         = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               enable,
  input  logic               frame_tick,
  input  logic               trigger,
  output logic [FRAME_W-1:0] frame_sel,
  output logic               active,
  output logic               done,
  output logic [1:0]         state_o
);
  localparam int TW = $clog2(TICKS_PER_FRAME + 1);
  localparam int PW = $clog2(2 * HOLD_REPEATS + 1);
  localparam logic [FRAME_W-1:0] NF  = FRAME_W'(NUM_FRAMES);
  localparam logic [FRAME_W-1:0] NF1 = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [FRAME_W-1:0] ONE = FRAME_W'(1);
  localparam logic [TW-1:0] TLAST = TW'(TICKS_PER_FRAME - 1);
  localparam logic [PW-1:0] PLAST = PW'(2 * HOLD_REPEATS - 1);
  typedef enum logic [1:0] {IDLE, STRIKE, HOLD, DECAY} st_t;
  st_t state, state_n;
  logic [FRAME_W-1:0] frm, frm_n;
  logic [TW-1:0] tick, tick_n;
  logic [PW-1:0] per, per_n;
  logic done_n, pe;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      frm   <= '0;
      tick  <= '0;
      per   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      frm   <= frm_n;
      tick  <= tick_n;
      per   <= per_n;
      done  <= done_n;
    end
  end
  always_comb begin
    pe      = frame_tick && tick == TLAST;
    state_n = state;
    frm_n   = frm;
    per_n   = per;
    done_n  = 1'b0;
    tick_n  = frame_tick ? (pe ? '0 : tick + 1'b1) : tick;
    if (!enable) begin
      state_n = IDLE;
      frm_n   = '0;
      tick_n  = '0;
      per_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          tick_n = '0;
          per_n  = '0;
          if (trigger) begin
            state_n = STRIKE;
            frm_n   = ONE;
          end
        end
        STRIKE: if (pe) begin
          if (frm == NF) begin
            state_n = HOLD;
            frm_n   = NF1;
            per_n   = '0;
          end else frm_n = frm + 1'b1;
        end
        HOLD: if (trigger) begin
          tick_n = '0;
          per_n  = '0;
        end else if (pe) begin
          if (per == PLAST) begin
            state_n = DECAY;
            frm_n   = NF1;
          end else begin
            frm_n = frm == NF ? NF1 : NF;
            per_n = per + 1'b1;
          end
        end
        DECAY: if (trigger) begin
          state_n = STRIKE;
          tick_n  = '0;
        end else if (pe) begin
          if (frm > ONE) frm_n = frm - 1'b1;
          else begin
            state_n = IDLE;
            frm_n   = '0;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_comb begin
    active  = state != IDLE;
    state_o = state;
  end
`ifdef BRICK_LIGHTNING_FLICKER_EN
  logic [3:0] lfsr, lfsr_n;
  always_comb lfsr_n = (state == HOLD && frame_tick) ? {lfsr[2:0], lfsr[3] ^ lfsr[2]} : lfsr;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr      <= 4'b1001;
      frame_sel <= '0;
    end else begin
      lfsr      <= lfsr_n;
      frame_sel <= (state_n == HOLD && lfsr_n[0]) ? '0 : frm_n;
    end
  end
`else
  assign frame_sel = frm;
`endif
endmodule

// File: tb/tb_brick_lightning_anim_ctrl.sv
// tb_brick_lightning_anim_ctrl: directed checks of the lightning-brick frame sequence
module tb_brick_lightning_anim_ctrl;
  logic Clk = 0, Reset = 0, enable = 0, frame_tick = 0, trigger = 0;
  logic [2:0] frame_sel;
  logic active, done;
  logic [1:0] state_o;
  int total = 0, bad = 0;
  int seq [11] = '{1, 2, 3, 4, 3, 4, 3, 4, 3, 2, 1};

  brick_lightning_anim_ctrl dut (
    .Clk(Clk), .Reset(Reset), .enable(enable), .frame_tick(frame_tick),
    .trigger(trigger), .frame_sel(frame_sel), .active(active), .done(done),
    .state_o(state_o)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1;
    cyc();
    frame_tick = 0;
  endtask

  task automatic gap();
    repeat (4) cyc();
  endtask

  task automatic do_reset();
    Reset = 1; trigger = 0; frame_tick = 0; enable = 1;
    cyc(); cyc();
    Reset = 0;
  endtask

  task automatic fire();
    trigger = 1;
    cyc();
    trigger = 0;
  endtask

  function automatic int st_at(int k);
    return k < 12 ? 1 : k < 24 ? 2 : k < 33 ? 3 : 0;
  endfunction

  task automatic test_reset();
    do_reset();
    total += 4;
    if (frame_sel !== 3'd0) begin bad++; $display("FAIL reset frame_sel got %0d want 0", frame_sel); end
    if (active !== 1'b0) begin bad++; $display("FAIL reset active got %b want 0", active); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset done got %b want 0", done); end
    if (state_o !== 2'd0) begin bad++; $display("FAIL reset state got %0d want 0", state_o); end
  endtask

  task automatic test_full_sequence();
    logic [3:0] l = 4'b1001;
    int ef;
    do_reset();
    fire();
    total += 3;
    if (frame_sel !== 3'd1) begin bad++; $display("FAIL full start frame got %0d want 1", frame_sel); end
    if (active !== 1'b1) begin bad++; $display("FAIL full start active got %b want 1", active); end
    if (state_o !== 2'd1) begin bad++; $display("FAIL full start state got %0d want 1", state_o); end
    for (int k = 1; k <= 40; k++) begin
      if (st_at(k - 1) == 2) l = {l[2:0], l[3] ^ l[2]};
      tick();
      ef = k < 33 ? seq[k / 3] : 0;
`ifdef BRICK_LIGHTNING_FLICKER_EN
      if (st_at(k) == 2 && l[0]) ef = 0;
`endif
      total += 4;
      if (frame_sel !== 3'(ef)) begin bad++; $display("FAIL full tick %0d frame got %0d want %0d", k, frame_sel, ef); end
      if (state_o !== 2'(st_at(k))) begin bad++; $display("FAIL full tick %0d state got %0d want %0d", k, state_o, st_at(k)); end
      if (done !== (k == 33)) begin bad++; $display("FAIL full tick %0d done got %b want %b", k, done, k == 33); end
      if (active & done) begin bad++; $display("FAIL full tick %0d active and done both 1", k); end
      cyc();
      total += 1;
      if (done !== 1'b0) begin bad++; $display("FAIL full tick %0d done after got %b want 0", k, done); end
      repeat (3) cyc();
    end
    total += 1;
    if (active !== 1'b0) begin bad++; $display("FAIL full end active got %b want 0", active); end
  endtask

  task automatic test_trigger_with_tick();
    do_reset();
    trigger = 1; frame_tick = 1;
    cyc();
    trigger = 0; frame_tick = 0;
    total += 2;
    if (frame_sel !== 3'd1) begin bad++; $display("FAIL trig_tick frame got %0d want 1", frame_sel); end
    if (state_o !== 2'd1) begin bad++; $display("FAIL trig_tick state got %0d want 1", state_o); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      total += 1;
      if (frame_sel !== (k < 3 ? 3'd1 : 3'd2)) begin bad++; $display("FAIL trig_tick tick %0d frame got %0d want %0d", k, frame_sel, k < 3 ? 1 : 2); end
      gap();
    end
  endtask

  task automatic test_decay_retrigger();
    int ef;
    do_reset();
    fire();
    repeat (29) begin tick(); gap(); end
    total += 2;
    if (frame_sel !== 3'd2 || state_o !== 2'd3) begin bad++; $display("FAIL decay pre frame %0d state %0d want 2 3", frame_sel, state_o); end
    fire();
    if (frame_sel !== 3'd2 || state_o !== 2'd1) begin bad++; $display("FAIL decay retrig frame %0d state %0d want 2 1", frame_sel, state_o); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      ef = k < 3 ? 2 : k < 6 ? 3 : k < 9 ? 4 : 3;
      total += 3;
      if (frame_sel !== 3'(ef)) begin bad++; $display("FAIL decay tick %0d frame got %0d want %0d", k, frame_sel, ef); end
      if (state_o !== (k < 9 ? 2'd1 : 2'd2)) begin bad++; $display("FAIL decay tick %0d state got %0d want %0d", k, state_o, k < 9 ? 1 : 2); end
      if (done !== 1'b0) begin bad++; $display("FAIL decay tick %0d done got %b want 0", k, done); end
      gap();
    end
  endtask

  task automatic test_hold_retrigger();
    int ef;
    do_reset();
    fire();
    repeat (21) begin tick(); gap(); end
    fire();
    total += 2;
    if (frame_sel !== 3'd4 || state_o !== 2'd2) begin bad++; $display("FAIL hold retrig frame %0d state %0d want 4 2", frame_sel, state_o); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      ef = k < 3 ? 4 : k < 6 ? 3 : k < 9 ? 4 : 3;
      total += 1;
      if (state_o !== (k < 12 ? 2'd2 : 2'd3)) begin bad++; $display("FAIL hold tick %0d state got %0d want %0d", k, state_o, k < 12 ? 2 : 3); end
      if (k % 3 == 0) begin
        total += 1;
        if (frame_sel !== 3'(ef)) begin bad++; $display("FAIL hold tick %0d frame got %0d want %0d", k, frame_sel, ef); end
      end
      gap();
    end
  endtask

  task automatic test_enable_and_reset_abort();
    do_reset();
    fire();
    repeat (6) begin tick(); gap(); end
    total += 1;
    if (frame_sel !== 3'd3) begin bad++; $display("FAIL abort pre frame got %0d want 3", frame_sel); end
    enable = 0;
    cyc();
    total += 4;
    if (frame_sel !== 3'd0) begin bad++; $display("FAIL enable frame got %0d want 0", frame_sel); end
    if (active !== 1'b0) begin bad++; $display("FAIL enable active got %b want 0", active); end
    if (state_o !== 2'd0) begin bad++; $display("FAIL enable state got %0d want 0", state_o); end
    if (done !== 1'b0) begin bad++; $display("FAIL enable done got %b want 0", done); end
    enable = 1;
    fire();
    repeat (15) begin tick(); gap(); end
    total += 1;
    if (state_o !== 2'd2) begin bad++; $display("FAIL reset pre state got %0d want 2", state_o); end
    Reset = 1; trigger = 1; frame_tick = 1;
    cyc();
    Reset = 0; trigger = 0; frame_tick = 0;
    total += 4;
    if (frame_sel !== 3'd0) begin bad++; $display("FAIL midreset frame got %0d want 0", frame_sel); end
    if (active !== 1'b0) begin bad++; $display("FAIL midreset active got %b want 0", active); end
    if (state_o !== 2'd0) begin bad++; $display("FAIL midreset state got %0d want 0", state_o); end
    if (done !== 1'b0) begin bad++; $display("FAIL midreset done got %b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_trigger_with_tick();
    test_decay_retrigger();
    test_hold_retrigger();
    test_enable_and_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
